// File: rtl/datasg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : datasg_pkg
// Description : Shared types for the multi-port data segmenter: FSM state
//               encoding and the per-port FIFO entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
package datasg_pkg;

  // Entry field widths; the top-level width parameters default to these
  localparam int DATA_W = 64;
  localparam int PRI_W  = 3;
  localparam int DES_W  = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  // One buffered ingress word
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [PRI_W-1:0]  prio;
    logic [DES_W-1:0]  des;
    logic              last;
  } fifo_entry_t;

endpackage
`default_nettype wire

// File: rtl/datasg_mp_if.sv
`default_nettype none
// ============================================================================
// Module      : datasg_mp_if
// Description : Ingress ports and SRAM write-side handshake of datasg_mp.
//               slave = segmenter view, master = environment view.
// Revision    : 1.0 - initial release
// ============================================================================
interface datasg_mp_if #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12,
  parameter int DES_WIDTH  = 4,
  parameter int PRI_WIDTH  = 3
);
  localparam int SRC_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0]            in_valid;
  logic [NUM_PORTS-1:0]            in_ready;
  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data;
  logic [NUM_PORTS*PRI_WIDTH-1:0]  in_priority;
  logic [NUM_PORTS*DES_WIDTH-1:0]  in_des;
  logic [NUM_PORTS-1:0]            in_last;
  logic                            busy;
  logic                            grant;
  logic                            request;
  logic [PRI_WIDTH-1:0]            wr_priority;
  logic [DES_WIDTH-1:0]            des_port;
  logic [ADDR_WIDTH-1:0]           address_write;
  logic [DATA_WIDTH-1:0]           data_write;
  logic                            wr_last;
  logic [SRC_WIDTH-1:0]            src_port;

  modport master (
    output in_valid, in_data, in_priority, in_des, in_last, busy, grant,
    input  in_ready, request, wr_priority, des_port, address_write,
           data_write, wr_last, src_port
  );

  modport slave (
    input  in_valid, in_data, in_priority, in_des, in_last, busy, grant,
    output in_ready, request, wr_priority, des_port, address_write,
           data_write, wr_last, src_port
  );

endinterface
`default_nettype wire

// File: rtl/datasg_fifo.sv
`default_nettype none
// ============================================================================
// Module      : datasg_fifo
// Description : Per-port synchronous FIFO of fifo_entry_t words with
//               asynchronous active-low reset and first-word-fall-through head.
// Revision    : 1.0 - initial release
// ============================================================================
module datasg_fifo
  import datasg_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  fifo_entry_t push_entry,
  input  logic        pop,
  output fifo_entry_t head,
  output logic        empty,
  output logic        full
);

  localparam int              PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0]  DEPTH_C = (PTR_W+1)'(DEPTH);

  fifo_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot a push into a full FIFO needs
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr_q];

  // Pointer and occupancy update; push+pop together leaves the count as is
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset empties the FIFO at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only observed through a non-empty head
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_entry;
  end

endmodule
`default_nettype wire

// File: rtl/datasg_mp.sv
`default_nettype none
// ============================================================================
// Module      : datasg_mp
// Description : Multi-port data segmenter. Buffers packets from NUM_PORTS
//               ingress ports, picks one packet by priority and streams it
//               to the SRAM write interface with sequential addresses.
//               Optional macro DATASG_MP_RR_EN: round-robin tie-breaking
//               (undefined: ties go to the lowest port index).
// Revision    : 1.0 - initial release
// ============================================================================
module datasg_mp
  import datasg_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = DATA_W,
  parameter int ADDR_WIDTH = 12,
  parameter int DES_WIDTH  = DES_W,
  parameter int PRI_WIDTH  = PRI_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  datasg_mp_if.slave  bus
);

  localparam int                SEL_W     = $clog2(NUM_PORTS);
  localparam logic [SEL_W:0]    NP        = (SEL_W+1)'(NUM_PORTS);
  localparam logic [SEL_W-1:0]  LAST_PORT = SEL_W'(NUM_PORTS - 1);

  fifo_entry_t           head [NUM_PORTS];
  fifo_entry_t           head_sel;
  logic [NUM_PORTS-1:0]  empty, full, push, pop;

  state_t                state_q, state_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [SEL_W-1:0]      rr_start;

  logic                  win_found;
  logic [SEL_W-1:0]      win_idx;
  logic [PRI_W-1:0]      win_pri;
  logic [SEL_W:0]        cand_sum;
  logic [SEL_W-1:0]      cand;

  logic                  show, request, xfer;

  // ---------------------------------------------------------------------------
  // Per-port ingress FIFOs
  // ---------------------------------------------------------------------------
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    fifo_entry_t push_entry;

    assign push_entry = '{data: bus.in_data[p*DATA_WIDTH +: DATA_WIDTH],
                          prio: bus.in_priority[p*PRI_WIDTH +: PRI_WIDTH],
                          des:  bus.in_des[p*DES_WIDTH +: DES_WIDTH],
                          last: bus.in_last[p]};
    assign push[p] = bus.in_valid[p] && !full[p];
    assign pop[p]  = xfer && (sel_q == SEL_W'(p));

    datasg_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push[p]),
      .push_entry (push_entry),
      .pop        (pop[p]),
      .head       (head[p]),
      .empty      (empty[p]),
      .full       (full[p])
    );
  end

  assign bus.in_ready = ~full;

  // ---------------------------------------------------------------------------
  // Tie-break start point
  // ---------------------------------------------------------------------------
`ifdef DATASG_MP_RR_EN
  logic [SEL_W-1:0] rr_q, rr_d;

  // Move the search start past the port whose packet just completed
  always_comb begin
    rr_d = rr_q;
    if (xfer && head_sel.last) begin
      rr_d = (sel_q == LAST_PORT) ? '0 : sel_q + SEL_W'(1);
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= '0;
    else        rr_q <= rr_d;
  end

  assign rr_start = rr_q;
`else
  assign rr_start = '0;
`endif

  // Highest head priority wins; scanning from rr_start with a strict compare
  // makes the first port in scan order win an equal-priority tie
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_pri   = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand_sum = {1'b0, rr_start} + (SEL_W+1)'(i);
      if (cand_sum >= NP) cand_sum = cand_sum - NP;
      cand = cand_sum[SEL_W-1:0];
      if (!empty[cand] && (!win_found || (head[cand].prio > win_pri))) begin
        win_found = 1'b1;
        win_idx   = cand;
        win_pri   = head[cand].prio;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Egress side: the locked port's head is presented while in XFER
  // ---------------------------------------------------------------------------
  assign head_sel = head[sel_q];
  assign show     = (state_q == XFER) && !empty[sel_q];
  assign request  = show && !bus.busy;
  assign xfer     = request && bus.grant;

  assign bus.request       = request;
  assign bus.wr_priority   = show ? head_sel.prio : '0;
  assign bus.des_port      = show ? head_sel.des  : '0;
  assign bus.data_write    = show ? head_sel.data : '0;
  assign bus.wr_last       = show ? head_sel.last : 1'b0;
  assign bus.address_write = addr_q;
  assign bus.src_port      = sel_q;

  // Next-state: lock a winner in IDLE, release the lock on the last word
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (!bus.busy && win_found) begin
          state_d = XFER;
          sel_d   = win_idx;
        end
      end
      XFER: begin
        if (xfer) begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          if (head_sel.last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, selected port and write-address counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_datasg_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_datasg_mp
// Description : Self-checking bench for datasg_mp: a vector table of single
//               word packets plus directed multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_datasg_mp;

  localparam int NP   = 4;
  localparam int DW   = 64;
  localparam int AW   = 12;
  localparam int DESW = 4;
  localparam int PW   = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  datasg_mp_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                 .DES_WIDTH(DESW), .PRI_WIDTH(PW)) bus ();

  datasg_mp #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
              .DES_WIDTH(DESW), .PRI_WIDTH(PW), .FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int             port;
    logic [PW-1:0]  prio;
    logic [DESW-1:0] des;
    logic [DW-1:0]  data;
    logic [AW-1:0]  exp_addr;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.in_valid    = '0;
    bus.in_data     = '0;
    bus.in_priority = '0;
    bus.in_des      = '0;
    bus.in_last     = '0;
  endtask

  task automatic load(input int p, input logic [DW-1:0] data, input logic [PW-1:0] prio,
                      input logic [DESW-1:0] des, input logic last);
    bus.in_valid[p]               = 1'b1;
    bus.in_data[p*DW +: DW]       = data;
    bus.in_priority[p*PW +: PW]   = prio;
    bus.in_des[p*DESW +: DESW]    = des;
    bus.in_last[p]                = last;
  endtask

  // Advance to the next falling edge; loaded words are pushed on the way
  task automatic tick();
    @(negedge clk);
    bus.in_valid = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    bus.grant = 1'b0;
    bus.busy  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Wait (bounded) for request, check the presented word, let grant take it
  task automatic expect_word(input string name, input int port, input logic [AW-1:0] addr,
                             input logic [DW-1:0] data, input logic last,
                             input logic [PW-1:0] prio, input logic [DESW-1:0] des);
    int waited = 0;
    while (bus.request !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (bus.request !== 1'b1) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: request low for %0d cycles, required high", name, waited);
    end else begin
      chk({name, "_src"},  64'(bus.src_port),      64'(port));
      chk({name, "_addr"}, 64'(bus.address_write), 64'(addr));
      chk({name, "_data"}, bus.data_write,         data);
      chk({name, "_last"}, 64'(bus.wr_last),       64'(last));
      chk({name, "_prio"}, 64'(bus.wr_priority),   64'(prio));
      chk({name, "_des"},  64'(bus.des_port),      64'(des));
      @(negedge clk);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [4];
    int   exp_port [6];
    int   exp_pkt  [6];

    vecs[0] = '{port: 0, prio: 3'd1, des: 4'h5, data: 64'h1111,                exp_addr: 12'd0};
    vecs[1] = '{port: 3, prio: 3'd7, des: 4'hF, data: 64'hDEADBEEF_CAFEF00D,   exp_addr: 12'd1};
    vecs[2] = '{port: 1, prio: 3'd0, des: 4'h0, data: 64'h0,                   exp_addr: 12'd2};
    vecs[3] = '{port: 2, prio: 3'd3, des: 4'h9, data: 64'hFFFFFFFF_FFFFFFFF,   exp_addr: 12'd3};

`ifdef DATASG_MP_RR_EN
    exp_port = '{0, 1, 2, 0, 1, 2};
    exp_pkt  = '{0, 0, 0, 1, 1, 1};
`else
    exp_port = '{0, 0, 1, 1, 2, 2};
    exp_pkt  = '{0, 1, 0, 1, 0, 1};
`endif

    // ---------------- reset values and first-word latency ----------------
    clear_inputs();
    bus.grant = 1'b0;
    bus.busy  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_request",  64'(bus.request),       64'd0);
    chk("rst_prio",     64'(bus.wr_priority),   64'd0);
    chk("rst_des",      64'(bus.des_port),      64'd0);
    chk("rst_addr",     64'(bus.address_write), 64'd0);
    chk("rst_data",     bus.data_write,         64'd0);
    chk("rst_last",     64'(bus.wr_last),       64'd0);
    chk("rst_src",      64'(bus.src_port),      64'd0);
    chk("rst_in_ready", 64'(bus.in_ready),      64'hF);
    rst_n = 1'b1;
    @(negedge clk);
    bus.grant = 1'b1;
    load(2, 64'hA5, 3'd0, 4'd3, 1'b1);
    tick();
    chk("lat_still_idle", 64'(bus.request), 64'd0);
    @(negedge clk);
    chk("lat_request",  64'(bus.request),       64'd1);
    chk("lat_addr",     64'(bus.address_write), 64'd0);
    chk("lat_src",      64'(bus.src_port),      64'd2);
    chk("lat_data",     bus.data_write,         64'hA5);
    chk("lat_des",      64'(bus.des_port),      64'd3);
    chk("lat_last",     64'(bus.wr_last),       64'd1);
    @(negedge clk);
    chk("lat_done_req",  64'(bus.request),       64'd0);
    chk("lat_done_addr", 64'(bus.address_write), 64'd1);

    // ---------------- vector table: single-word packets ----------------
    do_reset();
    bus.grant = 1'b1;
    for (int v = 0; v < 4; v++) begin
      load(vecs[v].port, vecs[v].data, vecs[v].prio, vecs[v].des, 1'b1);
      tick();
      expect_word($sformatf("vec%0d", v), vecs[v].port, vecs[v].exp_addr,
                  vecs[v].data, 1'b1, vecs[v].prio, vecs[v].des);
    end

    // ---------------- priority: higher priority served first ----------------
    do_reset();
    bus.grant = 1'b1;
    load(0, 64'h20, 3'd2, 4'd1, 1'b1);
    load(3, 64'h35, 3'd5, 4'd2, 1'b1);
    tick();
    expect_word("pri_first",  3, 12'd0, 64'h35, 1'b1, 3'd5, 4'd2);
    expect_word("pri_second", 0, 12'd1, 64'h20, 1'b1, 3'd2, 4'd1);

    // ---------------- equal-priority ties ----------------
    do_reset();
    bus.grant = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 3; p++) load(p, 64'(p * 16 + k), 3'd4, 4'(p), 1'b1);
      tick();
    end
    for (int s = 0; s < 6; s++) begin
      expect_word($sformatf("tie%0d", s), exp_port[s], AW'(s),
                  64'(exp_port[s] * 16 + exp_pkt[s]), 1'b1, 3'd4, 4'(exp_port[s]));
    end

    // ---------------- packet lock, grant stall and busy ----------------
    do_reset();
    load(1, 64'h100, 3'd1, 4'd4, 1'b0);
    tick();
    load(1, 64'h101, 3'd1, 4'd4, 1'b0);
    load(0, 64'h700, 3'd7, 4'd6, 1'b1);
    tick();
    load(1, 64'h102, 3'd1, 4'd4, 1'b1);
    tick();
    chk("lock_req_no_grant", 64'(bus.request),  64'd1);
    chk("lock_src",          64'(bus.src_port), 64'd1);
    bus.grant = 1'b1;
    expect_word("lock_w0", 1, 12'd0, 64'h100, 1'b0, 3'd1, 4'd4);
    bus.grant = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_addr", c), 64'(bus.address_write), 64'd1);
      chk($sformatf("stall%0d_src", c),  64'(bus.src_port),      64'd1);
    end
    bus.busy = 1'b1;
    #1;
    chk("busy_drops_req", 64'(bus.request), 64'd0);
    @(negedge clk);
    chk("busy_hold_addr", 64'(bus.address_write), 64'd1);
    bus.busy = 1'b0;
    #1;
    chk("busy_release_req", 64'(bus.request), 64'd1);
    bus.grant = 1'b1;
    expect_word("lock_w1",   1, 12'd1, 64'h101, 1'b0, 3'd1, 4'd4);
    expect_word("lock_w2",   1, 12'd2, 64'h102, 1'b1, 3'd1, 4'd4);
    expect_word("lock_next", 0, 12'd3, 64'h700, 1'b1, 3'd7, 4'd6);

    // ---------------- FIFO full ----------------
    do_reset();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("full_ready_%0d", i), 64'(bus.in_ready[0]), 64'(i < 4));
      load(0, 64'h500 + 64'(i), 3'd2, 4'd1, (i >= 3));
      tick();
    end
    chk("full_ready_after", 64'(bus.in_ready[0]), 64'd0);
    bus.grant = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_word($sformatf("full_w%0d", i), 0, AW'(i), 64'h500 + 64'(i), (i == 3), 3'd2, 4'd1);
    end
    begin
      bit extra = 1'b0;
      repeat (6) begin
        @(negedge clk);
        if (bus.request !== 1'b0) extra = 1'b1;
      end
      chk("full_no_extra_word", 64'(extra), 64'd0);
    end

    // ---------------- address wrap with a 4097-word packet ----------------
    do_reset();
    bus.grant = 1'b1;
    begin
      int pushed = 0;
      int xfers  = 0;
      int cyc    = 0;
      bit all_ok = 1'b1;
      while (xfers < 4097 && cyc < 5000) begin
        if (bus.request === 1'b1) begin
          if (bus.address_write !== AW'(xfers) || bus.data_write !== 64'(xfers)) all_ok = 1'b0;
          if (xfers == 4095) begin
            chk("wrap_top_addr", 64'(bus.address_write), 64'hFFF);
            chk("wrap_top_data", bus.data_write,         64'd4095);
          end
          if (xfers == 4096) begin
            chk("wrap_zero_addr", 64'(bus.address_write), 64'h000);
            chk("wrap_zero_data", bus.data_write,         64'd4096);
            chk("wrap_zero_last", 64'(bus.wr_last),       64'd1);
          end
          xfers++;
        end
        if (pushed < 4097) begin
          load(0, 64'(pushed), 3'd0, 4'd0, (pushed == 4096));
          if (bus.in_ready[0] === 1'b1) pushed++;
        end else begin
          bus.in_valid = '0;
        end
        @(negedge clk);
        cyc++;
      end
      bus.in_valid = '0;
      chk("wrap_count",      64'(xfers),        64'd4097);
      chk("wrap_all_words",  64'(all_ok),       64'd1);
      chk("wrap_throughput", 64'(cyc <= 4105),  64'd1);
    end

    // ---------------- reset in the middle of a packet ----------------
    do_reset();
    for (int i = 0; i < 4; i++) begin
      load(2, 64'hC0 + 64'(i), 3'd3, 4'd7, (i == 3));
      tick();
    end
    bus.grant = 1'b1;
    expect_word("mrst_w0", 2, 12'd0, 64'hC0, 1'b0, 3'd3, 4'd7);
    chk("mrst_w1_req", 64'(bus.request), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_req",      64'(bus.request),       64'd0);
    chk("mrst_addr",     64'(bus.address_write), 64'd0);
    chk("mrst_src",      64'(bus.src_port),      64'd0);
    chk("mrst_data",     bus.data_write,         64'd0);
    chk("mrst_in_ready", 64'(bus.in_ready),      64'hF);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      bit stale = 1'b0;
      repeat (6) begin
        @(negedge clk);
        if (bus.request !== 1'b0) stale = 1'b1;
      end
      chk("mrst_no_stale", 64'(stale), 64'd0);
    end
    load(1, 64'hBEEF, 3'd5, 4'd2, 1'b1);
    tick();
    expect_word("mrst_recover", 1, 12'd0, 64'hBEEF, 1'b1, 3'd5, 4'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/datasg_mp.md
# datasg_mp

Multi-port successor to the single-channel data segmenter in the SRAM controller write path. It accepts packet words from `NUM_PORTS` ingress ports into per-port FIFOs and picks one packet at a time by priority. It streams that packet's words to the SRAM controller write interface with a request/grant handshake, stamping each word with a sequential write address.

## Interface
- `NUM_PORTS`, 4: ingress port count (≥2).
- `DATA_WIDTH`, 64: word width.
- `ADDR_WIDTH`, 12: SRAM write address width.
- `DES_WIDTH`, 4: destination port field width.
- `PRI_WIDTH`, 3: priority width; larger value means more urgent.
- `FIFO_DEPTH`, 4: words per port FIFO; must be a power of two, ≥2.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  NUM_PORTS  per-port word valid.
- `in_ready`  out  NUM_PORTS  per-port FIFO not full.
- `in_data`  in  NUM_PORTS*DATA_WIDTH  packed words; port p occupies slice p.
- `in_priority`  in  NUM_PORTS*PRI_WIDTH  packed priority; taken from each word.
- `in_des`  in  NUM_PORTS*DES_WIDTH  packed destination.
- `in_last`  in  NUM_PORTS  marks the last word of a packet.
- `busy`  in  1  SRAM controller busy; suppresses `request`.
- `grant`  in  1  controller accepts the current word.
- `request`  out  1  word presented for write.
- `wr_priority`  out  PRI_WIDTH  priority of the current word.
- `des_port`  out  DES_WIDTH  destination of the current word.
- `address_write`  out  ADDR_WIDTH  write address.
- `data_write`  out  DATA_WIDTH  write data.
- `wr_last`  out  1  current word is the last of its packet.
- `src_port`  out  $clog2(NUM_PORTS)  ingress port being served.

## Operation
- Ingress: when `in_valid[p] && in_ready[p]` at a clock edge, port p pushes {data, priority, des, last}. `in_ready[p]` = !full[p]. Words are combinational with respect to count.
- FSM has two states: IDLE and XFER.
- IDLE → XFER when `!busy` and any FIFO head is valid.
  - Winner: the port whose head word has the highest `in_priority`.
  - Ties are broken by round-robin starting after the last served port.
  - The winner is latched in `sel`. `src_port` = `sel`.
- XFER: `request` = head[sel] valid && `!busy`.
  - `wr_priority`, `des_port`, `data_write`, `wr_last` come combinationally from head[sel]. They are 0 in IDLE.
  - Transfer happens on an edge where `request && grant`: pop head[sel] and `addr_ptr <= addr_ptr + 1`.
  - If the popped word had last=1, go to IDLE.
- Packet lock: no interleaving. Other ports wait until the locked packet's last word transfers, even if they hold higher priority.
- `address_write` = `addr_ptr`. The counter increments modulo 2^ADDR_WIDTH; 0xFFF+1 wraps to 0x000.
- `grant` while `request` is low is ignored.
- `busy` rising mid-packet drops `request`. Words are held, and the transfer resumes when `busy` falls.
- Selected FIFO empty mid-packet: `request` goes low and the FSM stays in XFER.
- Push and pop on the same FIFO in the same cycle: both take effect and the count is unchanged. This is allowed when full.

## Timing
- Reset values: `request` 0, `wr_priority` 0, `des_port` 0, `address_write` 0, `data_write` 0, `wr_last` 0, `src_port` 0.
- During and after reset: `in_ready` is all ones, all FIFOs are empty, the FSM is in IDLE, and the round-robin pointer is 0.
- Asserting `rst_n` low mid-packet discards all buffered words immediately.
- Latency: a word pushed into an empty FIFO at edge t makes the FSM enter XFER at edge t+1, with `request` high after t+1.
- Throughput inside a packet: one word per cycle while `grant` stays high.
- One IDLE cycle separates consecutive packets.

## Configuration
- `DATASG_MP_RR_EN` defined: equal-priority ties use round-robin. The pointer becomes `sel`+1 when a packet's last word transfers.
- `DATASG_MP_RR_EN` undefined: ties go to the lowest port index. No pointer register is built.

## Structure
- Package `datasg_pkg`: FSM state enum (IDLE, XFER) and the FIFO entry struct {data, priority, des, last}.
- Sub-module `datasg_fifo`: a synchronous FIFO with async active-low reset, instantiated `NUM_PORTS` times.
  - It exposes the head entry, `empty`, `full`, `push` and `pop`.
  - The arbiter and FSM live in the top level.

## Test plan
- Reset: `rst_n`=0 → all outputs 0 and `in_ready`=4'b1111. Release, push one word on port 2 (data 0xA5, des 3, last 1) with `grant`=1 → two cycles later `request`=1, `address_write`=0, `src_port`=2, then `address_write` becomes 1.
- Priority: ports 0 and 3 each push a single-word packet, priorities 2 and 5, same cycle → port 3 is served first, then port 0 at address+1.
- Ties (RR_EN defined): ports 0, 1 and 2 all at priority 4 with 2 packets each → service order 0, 1, 2, 0, 1, 2. Without the macro → 0, 0, 1, 1, 2, 2.
- Lock and backpressure: a 3-word packet on port 1 with `grant` low for 5 cycles mid-packet, while a priority-7 packet waits on port 0 → port 1 completes all 3 words before port 0 starts. `busy`=1 forces `request`=0.
- Full/wrap: push 5 words on one port with `grant`=0 → `in_ready` drops after the 4th word. Then preload `addr_ptr` near the top by streaming 4096 words → the address wraps from 0xFFF to 0x000.
- Mid-packet reset: pulse `rst_n` low during word 2 of a 4-word packet → `request`=0 immediately, and no stale words appear after release.
